// File: rtl/hex_display_scan.sv
// ============================================================================
// Module  : hex_display_scan
// Brief   : Time-multiplexed hex driver for common-anode 7-segment displays
//           with shadow registers, decimal points and leading-zero blanking.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_display_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    enable,
  input  logic                    blank_lz,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [7:0] C_SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

  logic [4*NUM_DIGITS-1:0] r_val;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;

  logic                    w_cnt_end;
  logic                    w_idx_end;
  logic [3:0]              w_nib;
  logic [6:0]              w_glyph;
  logic                    w_blank;
  logic [7:0]              w_seg_al;
  logic [7:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_an;
  logic [NUM_DIGITS:0]     w_zero;

  assign w_cnt_end = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_idx_end = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_nib     = r_val[{r_idx, 2'b00} +: 4];

  // w_zero[i]: digit i and every digit above it show nothing (nibble 0, no dp)
  assign w_zero[NUM_DIGITS] = 1'b1;
  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
      assign w_zero[i] = w_zero[i+1] & (r_val[4*i +: 4] == 4'h0) & ~r_dp[i];
    end
  endgenerate

  assign w_blank = blank_lz & (r_idx != '0) & w_zero[r_idx];

  always_comb begin
    w_glyph = 7'h7F;
    case (w_nib)
      4'h0: w_glyph = 7'h40;
      4'h1: w_glyph = 7'h79;
      4'h2: w_glyph = 7'h24;
      4'h3: w_glyph = 7'h30;
      4'h4: w_glyph = 7'h19;
      4'h5: w_glyph = 7'h12;
      4'h6: w_glyph = 7'h02;
      4'h7: w_glyph = 7'h78;
      4'h8: w_glyph = 7'h00;
      4'h9: w_glyph = 7'h10;
      4'hA: w_glyph = 7'h08;
      4'hB: w_glyph = 7'h03;
      4'hC: w_glyph = 7'h46;
      4'hD: w_glyph = 7'h21;
      4'hE: w_glyph = 7'h06;
      4'hF: w_glyph = 7'h0E;
      default: w_glyph = 7'h7F;
    endcase
  end

  always_comb begin
    w_an        = '1;
    w_an[r_idx] = 1'b0;
  end

  assign w_seg_al = w_blank ? 8'hFF : {~r_dp[r_idx], w_glyph};
  assign w_seg    = (SEG_ACT_LOW != 0) ? w_seg_al : ~w_seg_al;

  // Outputs follow the index registered on the previous edge, so a load that
  // coincides with an index advance is already visible on the new digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val      <= '0;
      r_dp       <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      an_out     <= '1;
      seg_out    <= C_SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        r_val <= value;
        r_dp  <= dp_in;
      end
      if (enable) begin
        an_out     <= w_an;
        seg_out    <= w_seg;
        frame_done <= w_cnt_end & w_idx_end;
        if (w_cnt_end) begin
          r_cnt <= '0;
          r_idx <= w_idx_end ? '0 : r_idx + IDX_W'(1);
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        an_out     <= '1;
        seg_out    <= C_SEG_OFF;
        frame_done <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hex_display_scan.sv
// ============================================================================
// Module  : tb_hex_display_scan
// Brief   : Self-checking bench for hex_display_scan (4 digits, divide by 4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hex_display_scan;

  localparam int ND  = 4;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        enable;
  logic        blank_lz;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  // reference model state: shadow regs and number of enabled cycles since reset
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  int          m_ticks;
  int          fd_count;

  hex_display_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .SEG_ACT_LOW(1)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .enable(enable), .blank_lz(blank_lz), .seg_out(seg_out), .an_out(an_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic       e_fd;
    int         d;
    bit         blank;
    if (enable) begin
      d     = (m_ticks / DIV) % ND;
      e_an  = ~(4'b0001 << d);
      blank = blank_lz && d != 0 && (m_val >> (4 * d)) == 0 && (m_dp >> d) == 0;
      e_seg = blank ? 8'hFF : {~m_dp[d], glyph(m_val[4*d +: 4])};
      e_fd  = (m_ticks % (DIV * ND)) == (DIV * ND - 1);
      m_ticks++;
    end else begin
      e_an  = 4'hF;
      e_seg = 8'hFF;
      e_fd  = 1'b0;
    end
    if (load) begin
      m_val = value;
      m_dp  = dp_in;
    end
    @(posedge clk);
    #1;
    check("an_out", {4'h0, an_out}, {4'h0, e_an});
    check("seg_out", seg_out, e_seg);
    check("frame_done", {7'h0, frame_done}, {7'h0, e_fd});
    if (frame_done) fd_count++;
  endtask

  task automatic model_reset();
    m_val   = '0;
    m_dp    = '0;
    m_ticks = 0;
  endtask

  initial begin
    rst = 1'b1; value = '0; dp_in = '0; load = 1'b0; enable = 1'b0; blank_lz = 1'b0;
    model_reset();
    #3;
    check("reset_an", {4'h0, an_out}, 8'h0F);
    check("reset_seg", seg_out, 8'hFF);
    check("reset_fd", {7'h0, frame_done}, 8'h00);
    #9 rst = 1'b0;

    // 12AF, no dp, no blanking: walk two full frames
    value = 16'h12AF; dp_in = 4'h0; load = 1'b1; enable = 1'b1;
    step();
    load = 1'b0;
    fd_count = 0;
    for (int i = 0; i < 32; i++) step();
    check("frame_count", fd_count[7:0], 8'd2);

    // asynchronous reset mid-scan, no clock edge
    repeat (5) step();
    #2 rst = 1'b1;
    #1;
    check("async_rst_an", {4'h0, an_out}, 8'h0F);
    check("async_rst_seg", seg_out, 8'hFF);
    check("async_rst_fd", {7'h0, frame_done}, 8'h00);
    #3 rst = 1'b0;
    model_reset();

    // leading-zero blanking, then the same value with a dp on digit 2
    value = 16'h0006; dp_in = 4'h0; blank_lz = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 16; i++) step();
    dp_in = 4'b0100; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 16; i++) step();

    // pause mid-digit-2 for 10 clocks
    while ((m_ticks / DIV) % ND != 2 || m_ticks % DIV != 1) step();
    enable = 1'b0;
    repeat (10) step();
    enable = 1'b1;
    repeat (12) step();

    // load on the index-advance edge
    blank_lz = 1'b0;
    while (m_ticks % DIV != DIV - 1) step();
    value = 16'h9C3D; dp_in = 4'b1010; load = 1'b1;
    step();
    load = 1'b0;
    repeat (8) step();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      value    = 16'($urandom >> (4 * $urandom_range(0, 4)));
      dp_in    = ($urandom % 3 == 0) ? 4'($urandom) : 4'h0;
      load     = ($urandom % 6 == 0);
      enable   = ($urandom % 8 != 0);
      blank_lz = 1'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
